// File: rtl/timer_pkg.sv
// Shared definitions for the interval timer: FSM state encoding and default width.
package timer_pkg;

    // FSM state encoding
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Default counter / period width
    localparam int TIMER_N = 16;

endpackage : timer_pkg

// File: rtl/bin_counter.sv
// Free-running binary up-counter with synchronous clear, parallel load and
// enable. Control priority is syn_clr > load > en. max_tick flags q = all ones.
module bin_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic         max_tick,
    output logic [N-1:0] q
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    // Next count: clear beats load, load beats increment
    always_comb begin
        q_d = q_q;
        if (syn_clr) begin
            q_d = '0;
        end else if (load) begin
            q_d = d;
        end else if (en) begin
            q_d = q_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q        = q_q;
    assign max_tick = &q_q;

endmodule : bin_counter

// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer controller. Sequences one bin_counter loaded
// with ~period so that it reaches all ones after exactly `period` enables.
// Supports one-shot and periodic operation with start/stop/hold control.
module interval_timer_ctrl
    import timer_pkg::*;
#(
    parameter int N = TIMER_N
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         hold,
    input  logic         periodic,
    input  logic [N-1:0] period,
    output logic         busy,
    output logic         done_tick,
    output logic [N-1:0] remaining
);

    logic [0:0]   state_q, state_d;
    logic [N-1:0] per_q,   per_d;
    logic         mode_q,  mode_d;

    logic         cnt_syn_clr;
    logic         cnt_load;
    logic         cnt_en;
    logic [N-1:0] cnt_d;
    logic         cnt_max_tick;
    logic [N-1:0] cnt_q;
    logic         done_d;

    bin_counter #(.N(N)) counter_unit (
        .clk      (clk),
        .reset    (reset),
        .syn_clr  (cnt_syn_clr),
        .load     (cnt_load),
        .en       (cnt_en),
        .d        (cnt_d),
        .max_tick (cnt_max_tick),
        .q        (cnt_q)
    );

    // FSM next-state, counter control and expiry strobe
    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        mode_d      = mode_q;
        cnt_syn_clr = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_d       = ~period;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    cnt_load = 1'b1;
                    cnt_d    = ~period;
                    per_d    = period;
                    mode_d   = periodic;
                    state_d  = RUN;
                end
            end

            RUN: begin
                if (stop) begin
                    // Abort wins over a coincident expiry: no strobe
                    cnt_syn_clr = 1'b1;
                    state_d     = IDLE;
                end else if (start) begin
                    // Restart from a freshly sampled period/mode
                    cnt_load = 1'b1;
                    cnt_d    = ~period;
                    per_d    = period;
                    mode_d   = periodic;
                end else if (hold) begin
                    // Counter frozen; a pending expiry waits for hold to drop
                    cnt_en = 1'b0;
                end else if (cnt_max_tick) begin
                    done_d = 1'b1;
                    if (mode_q) begin
                        // Reload from the latched period, not the live input
                        cnt_load = 1'b1;
                        cnt_d    = ~per_q;
                    end else begin
                        cnt_syn_clr = 1'b1;
                        state_d     = IDLE;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end

            default: begin
                cnt_syn_clr = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, latched period and latched mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            per_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
        end
    end

    // Outputs: remaining is the distance of q from all ones, forced to 0 in IDLE
    always_comb begin
        busy      = (state_q == RUN);
        done_tick = done_d;
        remaining = (state_q == RUN) ? ~cnt_q : '0;
    end

endmodule : interval_timer_ctrl

// File: tb/tb_interval_timer_ctrl.sv
// Self-checking bench for interval_timer_ctrl: directed scenarios plus
// randomized control, compared against a remaining-count reference model.
module tb_interval_timer_ctrl;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, stop, hold, periodic;
    logic [N-1:0] period;
    logic         busy, done_tick;
    logic [N-1:0] remaining;

    interval_timer_ctrl #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .hold      (hold),
        .periodic  (periodic),
        .period    (period),
        .busy      (busy),
        .done_tick (done_tick),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: running flag, cycles left, latched period and mode
    bit m_run;
    int m_rem;
    int m_per;
    bit m_mode;

    int cyc = 0;
    int ndone;
    int last_done;
    logic         o_busy;
    logic [N-1:0] o_rem;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 0;
        m_rem  = 0;
        m_per  = 0;
        m_mode = 0;
    endtask

    task automatic clear_track();
        ndone     = 0;
        last_done = -1;
    endtask

    // One clock cycle: drive at negedge, check just after, advance model at posedge
    task automatic step(input bit st, input bit sp, input bit hd, input bit pm, input logic [N-1:0] pr);
        bit exp_done;
        int exp_rem;
        start    = st;
        stop     = sp;
        hold     = hd;
        periodic = pm;
        period   = pr;
        #1;
        exp_done = m_run && !sp && !st && !hd && (m_rem == 0);
        exp_rem  = m_run ? m_rem : 0;
        check("busy", {31'b0, busy}, {31'b0, m_run});
        check("done_tick", {31'b0, done_tick}, {31'b0, exp_done});
        check("remaining", {16'b0, remaining}, exp_rem);
        o_busy = busy;
        o_rem  = remaining;
        if (done_tick) begin
            ndone++;
            last_done = cyc;
        end
        if (!m_run) begin
            if (st && !sp) begin
                m_run = 1; m_rem = int'(pr); m_per = int'(pr); m_mode = pm;
            end
        end else if (sp) begin
            m_run = 0;
        end else if (st) begin
            m_rem = int'(pr); m_per = int'(pr); m_mode = pm;
        end else if (hd) begin
            // frozen
        end else if (m_rem == 0) begin
            if (m_mode) m_rem = m_per;
            else        m_run = 0;
        end else begin
            m_rem = m_rem - 1;
        end
        cyc++;
        @(negedge clk);
    endtask

    // Idle cycle with junk on period/periodic, which must not matter
    task automatic idle();
        step(0, 0, 0, 1'($urandom), N'($urandom));
    endtask

    int t0;

    initial begin
        reset = 1'b1; start = 0; stop = 0; hold = 0; periodic = 0; period = '0;
        model_reset();
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done_tick}, 0);
        check("rst_rem", {16'b0, remaining}, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;

        // One-shot P=5
        clear_track(); t0 = cyc;
        step(1, 0, 0, 0, 16'd5);
        repeat (7) idle();
        check("os_done_at", last_done - t0, 6);
        check("os_ndone", ndone, 1);
        check("os_busy_end", {31'b0, o_busy}, 0);

        // Periodic P=3 for 20 cycles
        clear_track(); t0 = cyc;
        step(1, 0, 0, 1, 16'd3);
        repeat (20) idle();
        check("per_ndone", ndone, 5);
        check("per_last", last_done - t0, 20);
        check("per_busy", {31'b0, o_busy}, 1);
        step(0, 1, 0, 0, 16'd0);
        idle();
        check("per_stopped", {31'b0, o_busy}, 0);

        // P=0 one-shot
        clear_track(); t0 = cyc;
        step(1, 0, 0, 0, 16'd0);
        idle();
        idle();
        check("p0_done_at", last_done - t0, 1);
        check("p0_idle", {31'b0, o_busy}, 0);

        // Hold for cycles 4..6 with P=10
        clear_track(); t0 = cyc;
        step(1, 0, 0, 0, 16'd10);
        repeat (3) idle();
        repeat (3) step(0, 0, 1, 0, 16'd0);
        check("hold_frozen", {16'b0, o_rem}, 7);
        repeat (9) idle();
        check("hold_done_at", last_done - t0, 14);
        check("hold_ndone", ndone, 1);

        // Stop coincident with expiry
        clear_track(); t0 = cyc;
        step(1, 0, 0, 0, 16'd2);
        repeat (2) idle();
        step(0, 1, 0, 0, 16'd0);
        idle();
        check("stop_ndone", ndone, 0);
        check("stop_busy", {31'b0, o_busy}, 0);
        check("stop_rem", {16'b0, o_rem}, 0);

        // Restart at cycle 2 with P=4
        clear_track(); t0 = cyc;
        step(1, 0, 0, 0, 16'd2);
        idle();
        step(1, 0, 0, 0, 16'd4);
        repeat (6) idle();
        check("rs_done_at", last_done - t0, 7);
        check("rs_ndone", ndone, 1);

        // Full-range period
        clear_track(); t0 = cyc;
        step(1, 0, 0, 0, 16'hFFFF);
        for (int i = 0; i < 65540 && ndone == 0; i++) idle();
        check("pmax_done_at", last_done - t0, 65536);
        idle();
        check("pmax_idle", {31'b0, o_busy}, 0);

        // Asynchronous reset in the middle of a cycle while running
        step(1, 0, 0, 0, 16'd100);
        repeat (10) idle();
        #2;
        reset = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_done", {31'b0, done_tick}, 0);
        check("arst_rem", {16'b0, remaining}, 0);
        model_reset();
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        clear_track();
        repeat (4) idle();
        check("arst_stay_idle", {31'b0, o_busy}, 0);

        // Randomized control against the model
        clear_track();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 5) == 0),
                 1'($urandom),
                 ($urandom_range(0, 9) == 0) ? N'($urandom_range(0, 200))
                                             : N'($urandom_range(0, 12)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_interval_timer_ctrl
